// File: rtl/mmap_lsu_pkg.sv
// Shared types for the load/store unit and the mmap_region bus.
// Optional feature macro used by users of this package: MMAP_LSU_RMW_EN.
package base;

  localparam int CPU_WORD_W = 32;
  typedef logic [CPU_WORD_W-1:0] cpu_word;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    FAULT_NONE     = 3'd0,
    FAULT_MISALIGN = 3'd1,
    FAULT_ADDRESS  = 3'd2,
    FAULT_READ     = 3'd3,
    FAULT_WRITE    = 3'd4,
    FAULT_EINVAL   = 3'd5
  } mem_fault_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_WRITE  = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_t;

  // Natural alignment: halves on even addresses, words on multiples of 4.
  function automatic logic is_aligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~offset[0];
      SIZE_WORD: return offset == 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmap_region.sv
// Memory-region bus, read/write side. The CPU modport is the initiator;
// regions answer reads combinationally and commit writes on the clock edge.
interface mmap_region;

  base::cpu_word address_rw;
  logic          is_write;
  base::cpu_word write_word;
  base::cpu_word read_word;
  logic          fault_address;
  logic          fault_read;
  logic          fault_write;
  logic          fault_einval;
  logic          word_level_io;

  modport CPU (
    output address_rw, is_write, write_word,
    input  read_word, fault_address, fault_read, fault_write, fault_einval, word_level_io
  );

  modport REGION (
    input  address_rw, is_write, write_word,
    output read_word, fault_address, fault_read, fault_write, fault_einval, word_level_io
  );

endinterface

// File: rtl/mmap_lsu_lane.sv
// Byte-lane helper: little-endian load extraction with zero/sign extension
// and, with MMAP_LSU_RMW_EN defined, merging of sub-word store data into a word.
module lsu_lane
  import base::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] read_word_i,
`ifdef MMAP_LSU_RMW_EN
  input  logic [31:0] wdata_i,
  output logic [31:0] merge_o,
`endif
  output logic [31:0] load_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  assign shamt   = {offset_i, 3'b000};
  assign shifted = read_word_i >> shamt;

  // Right-align the addressed lane and extend it to a full word.
  always_comb begin
    case (mem_size_t'(size_i))
      SIZE_BYTE: load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:   load_o = shifted;
    endcase
  end

`ifdef MMAP_LSU_RMW_EN
  logic [31:0] lane_mask;
  logic [31:0] mask;

  // Overwrite only the addressed lane(s) of the word read back from the region.
  always_comb begin
    case (mem_size_t'(size_i))
      SIZE_BYTE: lane_mask = 32'h0000_00FF;
      SIZE_HALF: lane_mask = 32'h0000_FFFF;
      default:   lane_mask = 32'hFFFF_FFFF;
    endcase
    mask    = lane_mask << shamt;
    merge_o = (read_word_i & ~mask) | ((wdata_i << shamt) & mask);
  end
`endif

endmodule

// File: rtl/mmap_lsu.sv
// Load/store initiator for the mmap_region bus: one request at a time,
// sub-word loads extracted and extended in lsu_lane.
// MMAP_LSU_RMW_EN: when defined, sub-word stores are done as read-modify-write
// through the WRITE state; otherwise they are refused with EINVAL.
module mmap_lsu
  import base::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_fault,
  mmap_region.CPU     bus
);

  lsu_state_t  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  mem_size_t   size_q;
  logic        write_q;
  logic        signed_q;
  logic [31:0] rdata_q;
  mem_fault_t  fault_q;
`ifdef MMAP_LSU_RMW_EN
  logic [31:0] merge_q;
  logic [31:0] lane_merge;
  mem_fault_t  write_fault;
`endif

  logic [31:0] lane_load;
  logic [31:0] word_addr;
  logic        word_store;
  mem_fault_t  access_fault;

  assign word_addr  = {addr_q[31:2], 2'b00};
  assign word_store = write_q && (size_q == SIZE_WORD);
  assign req_ready  = (state_q == LSU_IDLE);
  assign rsp_valid  = (state_q == LSU_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_fault  = fault_q;

  lsu_lane u_lane (
    .size_i      (size_q),
    .offset_i    (addr_q[1:0]),
    .signed_i    (signed_q),
    .read_word_i (bus.read_word),
`ifdef MMAP_LSU_RMW_EN
    .wdata_i     (wdata_q),
    .merge_o     (lane_merge),
`endif
    .load_o      (lane_load)
  );

  // Fault cause for the ACCESS cycle: ADDRESS > EINVAL > READ/WRITE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    access_fault = FAULT_NONE;
    if (bus.fault_address)     access_fault = FAULT_ADDRESS;
    else if (bus.fault_einval) access_fault = FAULT_EINVAL;
    else if (word_store)       access_fault = bus.fault_write ? FAULT_WRITE : FAULT_NONE;
    else if (bus.fault_read)   access_fault = FAULT_READ;
  end

`ifdef MMAP_LSU_RMW_EN
  // Fault cause for the write-back half of a read-modify-write.
  always_comb begin
    write_fault = FAULT_NONE;
    if (bus.fault_address)     write_fault = FAULT_ADDRESS;
    else if (bus.fault_einval) write_fault = FAULT_EINVAL;
    else if (bus.fault_write)  write_fault = FAULT_WRITE;
  end
`endif

  // Bus drive is a pure decode of state, so reset drops is_write at once.
  always_comb begin
    bus.address_rw = '0;
    bus.is_write   = 1'b0;
    bus.write_word = '0;
    case (state_q)
      LSU_ACCESS: begin
        bus.address_rw = word_addr;
        bus.is_write   = word_store;
        bus.write_word = wdata_q;
      end
`ifdef MMAP_LSU_RMW_EN
      LSU_WRITE: begin
        bus.address_rw = word_addr;
        bus.is_write   = 1'b1;
        bus.write_word = merge_q;
      end
`endif
      default: ;
    endcase
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the request registers are a handful of flops, so all of them are reset for clean X-free state.
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SIZE_BYTE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= FAULT_NONE;
`ifdef MMAP_LSU_RMW_EN
      merge_q  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= mem_size_t'(req_size);
            write_q  <= req_write;
            signed_q <= req_signed;
            if (!is_aligned(mem_size_t'(req_size), req_addr[1:0])) begin
              rdata_q <= '0;
              fault_q <= FAULT_MISALIGN;
              state_q <= LSU_RESP;
            end else begin
              state_q <= LSU_ACCESS;
            end
          end
        end
        LSU_ACCESS: begin
          rdata_q <= '0;
          state_q <= LSU_RESP;
          if (access_fault != FAULT_NONE) begin
            fault_q <= access_fault;
          end else if (!write_q) begin
            rdata_q <= lane_load;
            fault_q <= FAULT_NONE;
          end else if (word_store) begin
            fault_q <= FAULT_NONE;
          end else begin
`ifdef MMAP_LSU_RMW_EN
            // Reads of word-level I/O have side effects, so no read-modify-write there.
            if (bus.word_level_io) begin
              fault_q <= FAULT_EINVAL;
            end else begin
              merge_q <= lane_merge;
              state_q <= LSU_WRITE;
            end
`else
            fault_q <= FAULT_EINVAL;
`endif
          end
        end
`ifdef MMAP_LSU_RMW_EN
        LSU_WRITE: begin
          fault_q <= write_fault;
          state_q <= LSU_RESP;
        end
`endif
        LSU_RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            fault_q <= FAULT_NONE;
            state_q <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_lsu.sv
// Self-checking bench for mmap_lsu. The bench plays the memory region and
// holds a request-level model of the expected response and bus activity.
module tb_mmap_lsu;
  import base::*;

`ifdef MMAP_LSU_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_fault;

  always #5 clk = ~clk;

  mmap_region bus_if ();

  // Region model: combinational read, write committed on the edge unless faulted.
  logic [31:0] mem [0:1023];
  bit f_addr = 0, f_einval = 0, f_read = 0, f_write = 0, f_wlio = 0;

  assign bus_if.read_word     = mem[bus_if.address_rw[11:2]];
  assign bus_if.fault_address = f_addr;
  assign bus_if.fault_einval  = f_einval;
  assign bus_if.fault_read    = f_read;
  assign bus_if.fault_write   = f_write;
  assign bus_if.word_level_io = f_wlio;

  always @(posedge clk)
    if (bus_if.is_write && !f_addr && !f_write && !f_einval)
      mem[bus_if.address_rw[11:2]] = bus_if.write_word;

  mmap_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .bus        (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the outstanding request, read by the per-cycle compare process.
  bit          chk_en = 0;
  bit          m_busy = 0;
  bit          m_mis = 0;
  int          cyc = 0;
  int          m_acc = 0;
  int          m_lat = 0;
  int          m_wr_off = 0;
  logic [31:0] m_rdata = '0;
  logic [2:0]  m_fault = '0;
  logic [31:0] m_bus_addr = '0;
  logic [31:0] last_rdata = '0;
  logic [2:0]  last_fault = '0;
  bit          c_ev, c_iw;
  logic [31:0] c_ea;

  // Compare every cycle, 2 ns after the edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (chk_en) begin
      c_ev = m_busy && (cyc >= m_acc + m_lat);
      c_iw = m_busy && (m_wr_off > 0) && (cyc == m_acc + m_wr_off);
      c_ea = (m_busy && !m_mis && cyc > m_acc && cyc < m_acc + m_lat) ? m_bus_addr : 32'h0;
      check("rsp_valid", 32'(rsp_valid), 32'(c_ev));
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("address_rw", bus_if.address_rw, c_ea);
      check("is_write", 32'(bus_if.is_write), 32'(c_iw));
      if (c_ev) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_fault", 32'(rsp_fault), 32'(m_fault));
      end
    end
  end

  // One transaction: derive expectations from the request rules, drive it, accept the response.
  task automatic run(input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] word, newword, b, r;
    int off, nb;
    logic [2:0] flt;
    int lat, wr_off;
    bit mis;
    word = mem[a[11:2]];
    newword = word;
    off = int'(a[1:0]);
    r = '0;
    flt = 3'd0;
    wr_off = 0;
    lat = 2;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (mis) begin
      lat = 1;
      flt = 3'd1;
    end else begin
      if (wr && sz == 2'd2) wr_off = 1;
      if (f_addr) flt = 3'd2;
      else if (f_einval) flt = 3'd5;
      else if (wr && sz == 2'd2) flt = f_write ? 3'd4 : 3'd0;
      else if (f_read) flt = 3'd3;
      else if (!wr) begin
        b = word >> (8 * off);
        if (sz == 2'd0) begin
          r = {24'h0, b[7:0]};
          if (sg && b[7]) r[31:8] = '1;
        end else if (sz == 2'd1) begin
          r = {16'h0, b[15:0]};
          if (sg && b[15]) r[31:16] = '1;
        end else r = b;
      end else if (!RMW || f_wlio) flt = 3'd5;
      else begin
        lat = 3;
        wr_off = 2;
        flt = f_write ? 3'd4 : 3'd0;
        nb = (sz == 2'd0) ? 1 : 2;
        if (!f_write)
          for (int j = 0; j < nb; j++) newword[8*(off+j) +: 8] = wd[8*j +: 8];
      end
      if (wr && sz == 2'd2 && !f_addr && !f_einval && !f_write) newword = wd;
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    m_mis = mis; m_lat = lat; m_wr_off = wr_off; m_rdata = r; m_fault = flt;
    m_bus_addr = {a[31:2], 2'b00};
    m_acc = cyc; m_busy = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      m_busy = 1'b0;
      return;
    end
    last_rdata = rsp_rdata;
    last_fault = rsp_fault;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    m_busy = 1'b0;
    check("mem_after", mem[a[11:2]], newword);
  endtask

  task automatic clear_faults();
    f_addr = 0; f_einval = 0; f_read = 0; f_write = 0; f_wlio = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Reset state.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_is_write", 32'(bus_if.is_write), 32'd0);
    check("rst_address_rw", bus_if.address_rw, 32'd0);
    check("rst_write_word", bus_if.write_word, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Loads.
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    run(0, 2'd2, 0, 32'h100, 32'h0, 0);
    check("pin_word_load", last_rdata, 32'hDEADBEEF);
    mem[32'h100 >> 2] = 32'h80FF0011;
    run(0, 2'd0, 1, 32'h103, 32'h0, 0);
    check("pin_sbyte_load", last_rdata, 32'hFFFFFF80);
    run(0, 2'd0, 0, 32'h103, 32'h0, 1);
    check("pin_ubyte_load", last_rdata, 32'h00000080);
    run(0, 2'd1, 1, 32'h102, 32'h0, 0);
    check("pin_shalf_load", last_rdata, 32'hFFFF80FF);
    run(0, 2'd1, 0, 32'h100, 32'h0, 0);
    run(0, 2'd0, 1, 32'h101, 32'h0, 4);

    // Sub-word stores.
    mem[32'h200 >> 2] = 32'h11223344;
    run(1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0);
    check("pin_half_store", mem[32'h200 >> 2], RMW ? 32'hABCD3344 : 32'h11223344);
    check("pin_half_fault", 32'(last_fault), RMW ? 32'd0 : 32'd5);
    mem[32'h210 >> 2] = 32'h11223344;
    run(1, 2'd0, 0, 32'h211, 32'hFFFFFF5A, 3);

    // Misaligned and illegal size: no bus activity.
    run(0, 2'd1, 0, 32'h201, 32'h0, 0);
    check("pin_misalign", 32'(last_fault), 32'd1);
    run(0, 2'd3, 0, 32'h200, 32'h0, 0);
    run(1, 2'd2, 0, 32'h206, 32'h12345678, 2);

    // Word store.
    run(1, 2'd2, 0, 32'h220, 32'hCAFEF00D, 0);
    check("pin_word_store", mem[32'h220 >> 2], 32'hCAFEF00D);

    // Fault priority.
    f_addr = 1; f_einval = 1; f_write = 1;
    run(1, 2'd2, 0, 32'h224, 32'h01020304, 0);
    check("pin_addr_fault", 32'(last_fault), 32'd2);
    clear_faults();
    f_einval = 1; f_read = 1;
    run(0, 2'd2, 0, 32'h100, 32'h0, 0);
    clear_faults();
    f_read = 1;
    run(0, 2'd0, 0, 32'h100, 32'h0, 0);
    clear_faults();
    f_write = 1;
    run(0, 2'd2, 0, 32'h100, 32'h0, 0);
    run(1, 2'd2, 0, 32'h228, 32'h0BAD0BAD, 0);
    mem[32'h240 >> 2] = 32'h55667788;
    run(1, 2'd1, 0, 32'h240, 32'h00009999, 0);
    clear_faults();

    // Word-level I/O refuses sub-word stores.
    f_wlio = 1;
    mem[32'h230 >> 2] = 32'hA5A5A5A5;
    run(1, 2'd0, 0, 32'h230, 32'h0000003C, 0);
    check("pin_wlio_einval", 32'(last_fault), 32'd5);
    run(1, 2'd2, 0, 32'h234, 32'h77777777, 0);
    clear_faults();

    // Reset during ACCESS of a word store.
    mem[32'h300 >> 2] = 32'h0BADF00D;
    @(negedge clk);
    chk_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check("pre_rst_is_write", 32'(bus_if.is_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop_is_write", 32'(bus_if.is_write), 32'd0);
    check("rst_drop_address", bus_if.address_rw, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_mem", mem[32'h300 >> 2], 32'h0BADF00D);
    chk_en = 1'b1;
    run(0, 2'd2, 0, 32'h300, 32'h0, 0);
    check("pin_post_rst_load", last_rdata, 32'h0BADF00D);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmap_lsu.md
# mmap_lsu

Load/store initiator for the `mmap_region` bus: accepts one data request at a time from the CPU execute stage, drives the read/write side of the bus, and returns load data or a fault cause. It is the initiating end of the protocol that memory regions (ROM, RAM, MMIO) respond to. Sub-word stores are done as read-modify-write, and sub-word loads are extracted and extended. The exec side of the bus belongs to the fetch unit and is not driven here.

## Interface
- Parameters: none. Widths come from `base::cpu_word` (32 bits).
- `clk` in 1: system clock, the same clock the bus regions use.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: `mem_size_t`; BYTE=0, HALF=1, WORD=2; 3 is illegal.
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out 32: load result; 0 for stores and faults.
- `rsp_fault` out 3: `mem_fault_t` cause; NONE on success.
- `bus` modport `mmap_region.CPU`. This block drives `address_rw`, `is_write` and `write_word`. It samples `read_word`, `fault_address`, `fault_read`, `fault_write`, `fault_einval` and `word_level_io`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - On `req_valid`, register the request.
  - Check alignment: HALF needs `addr[0]=0`, WORD needs `addr[1:0]=0`, and size 3 is illegal.
  - If the check fails, go to RESP with MISALIGN. No bus cycle is issued.
  - Otherwise go to ACCESS.
- **ACCESS**
  - `address_rw = {addr_q[31:2],2'b00}`.
  - `is_write=1` only for WORD stores; `write_word=wdata_q`.
  - Fault priority: ADDRESS > EINVAL > READ (loads and sub-word stores) or WRITE (word stores).
  - Any fault goes to RESP with that cause.
  - Load: extract the lane at `addr_q[1:0]` from `read_word` (little-endian), zero- or sign-extend it, and go to RESP.
  - WORD store: go to RESP.
  - Sub-word store:
    - If `word_level_io=1`, the region's reads have side effects. Go to RESP with EINVAL and issue no write.
    - Otherwise merge `wdata_q` into the captured `read_word` lane(s), hold the result in `merge_q`, and go to WRITE.
- **WRITE**
  - `address_rw` as in ACCESS, `is_write=1`, `write_word=merge_q`.
  - A `fault_address`, `fault_write` or `fault_einval` fault is reported with its cause. The write strobe is still presented; regions gate their own writes on faults.
  - Go to RESP.
- **RESP**
  - `rsp_valid=1` and all response outputs stay stable.
  - When `rsp_ready=1`, go to IDLE.
- Outside ACCESS and WRITE: `is_write=0`, `address_rw=0`, `write_word=0`.
- `is_write` is a pure decode of the state register, so an asserted `rst_n` drops it immediately.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=NONE`, `is_write=0`, `address_rw=0`, `write_word=0`.
- Bus reads are combinational within the ACCESS cycle. Writes commit at the rising edge that ends the cycle.
- Request accepted at edge N:
  - Load or WORD store: `rsp_valid` from N+2.
  - Sub-word store: `rsp_valid` from N+3.
  - Misaligned request: `rsp_valid` from N+1.
- Response accepted at edge M: `req_ready` is high at M+1. There is no request/response overlap, so throughput is at most one access per 3 cycles.
- Reset during ACCESS or WRITE: the operation is abandoned and no response is produced. A write is issued only if an edge with `is_write=1` happened before reset.
- `rsp_valid` holding with `rsp_ready=0`: the response is held indefinitely and no new request is accepted.

## Configuration
- `MMAP_LSU_RMW_EN` defined: sub-word stores use the ACCESS→WRITE read-modify-write path described above.
- Undefined:
  - A sub-word store goes ACCESS→RESP with EINVAL and makes no bus write.
  - `is_write` is never asserted for it.
  - The WRITE state and `merge_q` are removed.

## Structure
- Add to package `base`: `mem_size_t`, `mem_fault_t` (NONE, MISALIGN, ADDRESS, READ, WRITE, EINVAL), and `lsu_state_t`.
- One sub-module, `lsu_lane`: purely combinational. It handles lane extraction with sign/zero extension and store merge, keyed on size and `addr[1:0]`.

## Test plan
- WORD load at 0x100, region returns 0xDEADBEEF → `rsp_rdata=0xDEADBEEF`, NONE, `rsp_valid` two cycles after accept.
- Signed BYTE load at 0x103 from 0x80FF0011 → 0xFFFFFF80. Unsigned → 0x00000080.
- HALF store 0xABCD at 0x202 (RMW on), memory 0x11223344 → one write of 0xABCD3344, response on cycle N+3.
- HALF load at 0x201 → MISALIGN at N+1 with no bus activity. Region `fault_address` on a WORD store → ADDRESS and no other cause.
- BYTE store to a `word_level_io=1` region → EINVAL with `is_write` never high. With the macro undefined, the same result occurs for any region.
- `rst_n` asserted during ACCESS of a WORD store → `is_write` drops the same cycle, and after release `req_ready=1` and `rsp_valid=0`.
